// File: rtl/mem_arbiter_if.sv
// Request/RAM bundle for mem_arbiter: fetch port, data port, RAM side and
// sticky error flags. The arbiter takes the slave modport; the
// requesters plus the RAM model together act as master.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    logic              timeout_err;
    logic              req_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output timeout_err, req_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  timeout_err, req_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// Data wins by default; a streak counter forces a fetch grant after
// MAX_DSTREAK consecutive data grants taken while a fetch was waiting.
// A per-access watchdog aborts a grant the RAM never answers.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate pending requests
// IFETCH | fetch address on the RAM, waiting for ramready
// DACC   | data read or write on the RAM, waiting for ramready
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam int DSW = $clog2(MAX_DSTREAK + 1);
    localparam int TW  = $clog2(TIMEOUT);
    localparam logic [DSW-1:0] DS_MAX = DSW'(MAX_DSTREAK);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DACC   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [DSW-1:0] dstreak_q, dstreak_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           dop_rd_q, dop_rd_d;
    logic           terr_q, terr_d;
    logic           rerr_q, rerr_d;

    logic              dreq;
    logic              held;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;

    assign dreq = bus.dREN | bus.dWEN;

    // State and bookkeeping registers; async reset clears any access in flight.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            tcnt_q    <= '0;
            dop_rd_q  <= 1'b0;
            terr_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            tcnt_q    <= tcnt_d;
            dop_rd_q  <= dop_rd_d;
            terr_q    <= terr_d;
            rerr_q    <= rerr_d;
        end
    end

    // Next-state: arbitration in IDLE, completion/abort/watchdog in grant states.
    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        tcnt_d    = tcnt_q;
        dop_rd_d  = dop_rd_q;
        terr_d    = terr_q;
        rerr_d    = rerr_q;
        held      = 1'b0;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (bus.dREN && bus.dWEN) begin
                    rerr_d = 1'b1;
                end
                if (dreq && !(bus.iREN && dstreak_q == DS_MAX)) begin
                    state_d  = DACC;
                    // both strobes high resolves to a write
                    dop_rd_d = bus.dREN & ~bus.dWEN;
                    // this branch is unreachable with dstreak at DS_MAX and
                    // iREN high, so the increment cannot pass the limit
                    if (bus.iREN) begin
                        dstreak_d = dstreak_q + DSW'(1);
                    end
                end else if (bus.iREN) begin
                    state_d   = IFETCH;
                    dstreak_d = '0;
                end
            end

            IFETCH, DACC: begin
                held = (state_q == IFETCH) ? bus.iREN : dreq;
                if (bus.ramready || !held) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end else if (tcnt_q == T_LAST) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    terr_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    // RAM strobes, address and write data decoded from the granted port.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        case (state_q)
            IFETCH: begin
                ram_ren  = 1'b1;
                ram_addr = bus.iaddr;
            end
            DACC: begin
                ram_ren   = dop_rd_q;
                ram_wen   = ~dop_rd_q;
                ram_addr  = bus.daddr;
                ram_store = bus.dstore;
            end
            default: begin
                ram_ren = 1'b0;
            end
        endcase
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;

    assign bus.iwait = bus.iREN & ~((state_q == IFETCH) & bus.ramready);
    assign bus.dwait = dreq & ~((state_q == DACC) & bus.ramready);
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    assign bus.timeout_err = terr_q;
    assign bus.req_err     = rerr_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences all datapath memory traffic onto the single-ported RAM.
- Two requesters: the instruction fetch port and the data load/store port.
- Data requests have priority, but a streak limit guarantees fetch progress. A watchdog flags a RAM that stops responding.
- Sits between the datapath/request unit and the RAM model. Returns per-port wait/load signals.

Parameters:
ADDR_W, 32, width of the word-aligned byte address
DATA_W, 32, width of the data word
MAX_DSTREAK, 4, max consecutive data grants while a fetch is pending (>=1)
TIMEOUT, 64, cycles in a grant state without ramready before abort (>=2)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous, active-high reset (1 = reset)
iREN  in  1  instruction fetch request
iaddr  in  ADDR_W  fetch address
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data to write
iwait  out  1  fetch not complete this cycle
iload  out  DATA_W  fetched word, valid when iREN=1 and iwait=0
dwait  out  1  data access not complete this cycle
dload  out  DATA_W  read word, valid when dREN=1 and dwait=0
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid with ramready
ramready  in  1  RAM completes the current access this cycle
timeout_err  out  1  sticky: a RAM access timed out
req_err  out  1  sticky: dREN and dWEN both seen high in IDLE

Behaviour:
- Reset values:
  - state=IDLE; dstreak=0; tcnt=0; timeout_err=0; req_err=0.
  - ramREN=ramWEN=0; ramaddr=0; ramstore=0.
- Wait signals are combinational from the current state:
  - iwait = iREN & ~(state==IFETCH & ramready).
  - dwait = (dREN|dWEN) & ~(state==DACC & ramready).
- iload and dload pass ramload through combinationally. They are qualified only by the wait rules above.
- RAM outputs are combinational from the latched request:
  - IFETCH: ramREN=1, ramaddr=iaddr.
  - DACC: ramREN=dop_rd, ramWEN=~dop_rd, ramaddr=daddr, ramstore=dstore.
  - IDLE: both strobes 0.
- dop_rd is latched on entry to DACC; dREN&~dWEN gives read.
- Requesters must hold request and address stable until their wait drops.
- FSM states IDLE, IFETCH, DACC. Transitions from IDLE:
  - (dREN|dWEN) & ~(iREN & dstreak==MAX_DSTREAK) -> DACC. dstreak += iREN ? 1 : 0.
  - else iREN -> IFETCH; dstreak=0.
  - else stay in IDLE.
- dREN&dWEN together in IDLE: treated as a write, and req_err is set.
- IFETCH/DACC:
  - ramready=1 -> IDLE next cycle. Completion is exactly one wait-low cycle.
  - Requester drops its request before ramready -> abort to IDLE next cycle; strobes drop.
  - Otherwise tcnt += 1. When tcnt reaches TIMEOUT-1 with no ramready: set timeout_err, go to IDLE. Wait stays high and the requester's held request re-arbitrates.
  - tcnt clears on every entry to IDLE.
- Minimum latency: request at cycle 0 in IDLE, grant state at cycle 1, completes at cycle 1 if ramready=1. Back-to-back grants need one IDLE cycle each.
- No grant changes mid-access; a new request during an access waits for IDLE.
- Sticky errors clear only on reset.
- Reset mid-access: all state and strobes clear immediately (asynchronous); no partial write is held.
- dstreak saturates at MAX_DSTREAK and never wraps.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40, ramready at the first IFETCH cycle, ramload=0x2400000A -> ramREN=1, ramaddr=0x40 in cycle 1; iwait=0 with iload=0x2400000A in cycle 1; IDLE in cycle 2.
- Priority: iREN and dREN both high from cycle 0 -> DACC granted first with ramaddr=daddr; IFETCH follows after an IDLE cycle; iwait stays high throughout the data access.
- Starvation: iREN held and dWEN pulsed back-to-back for 6 requests, MAX_DSTREAK=4 -> 4 data grants, then IFETCH, then the remaining data grants; dstreak returns to 0.
- Timeout: dREN=1, ramready held 0, TIMEOUT=64 -> timeout_err=1 after 64 cycles in DACC; next cycle IDLE; DACC re-entered the following cycle; dwait=1 throughout.
- Abort and error: dREN&dWEN=1 in IDLE -> ramWEN=1 and req_err=1. Separately, dropping iREN mid-IFETCH -> ramREN=0 next cycle and state IDLE.
- Reset mid-write: nRST=1 during DACC write -> ramWEN=0 and all outputs at reset values in the same cycle; no access after release until a new request.
